// File: rtl/uart_cmd_frame_rx.sv
// uart_cmd_frame_rx: framed command parser behind the UART byte receiver.
// Frame: 55 A5 T3 T2 T1 T0 CTRL [CHK] F0. A good frame atomically commits
// {T3..T0} to time_set and CTRL to ctrl. Bad header2/tail/checksum and
// inter-byte timeouts raise a one-cycle frame_err and bump a saturating count.
// Build option: define UART_CMD_CHECKSUM_EN to add the XOR checksum byte (CHK).
module uart_cmd_frame_rx #(
  parameter int unsigned TIMEOUT_CYC  = 500_000,
  parameter logic [31:0] TIME_DEFAULT = 32'd24_999_999,
  parameter logic [7:0]  CTRL_DEFAULT = 8'h00
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [31:0] time_set,
  output logic [7:0]  ctrl,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] B_HDR1 = 8'h55;
  localparam logic [7:0] B_HDR2 = 8'hA5;
  localparam logic [7:0] B_TAIL = 8'hF0;

  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_DATA,
`ifdef UART_CMD_CHECKSUM_EN
    S_CHK,
`endif
    S_TAIL
  } state_t;

  state_t          state, state_nxt;
  logic [4:0][7:0] shadow;   // [0]=T3 .. [3]=T0, [4]=CTRL
  logic [2:0]      idx;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            commit;
  logic            err;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit = (state != S_IDLE) && !rx_done && (tmo_cnt == TMO_LAST);

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] chk_xor;
  assign chk_xor = shadow[0] ^ shadow[1] ^ shadow[2] ^ shadow[3] ^ shadow[4];
`endif

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; commit/err are single-cycle events registered below.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    err       = 1'b0;
    if (tmo_hit) begin
      state_nxt = S_IDLE;
      err       = 1'b1;
    end else if (rx_done) begin
      case (state)
        S_IDLE: begin
          if (rx_data == B_HDR1) state_nxt = S_HDR2;
        end
        S_HDR2: begin
          if (rx_data == B_HDR2) state_nxt = S_DATA;
          else if (rx_data == B_HDR1) state_nxt = S_HDR2;  // resync on repeated 0x55
          else begin
            state_nxt = S_IDLE;
            err       = 1'b1;
          end
        end
        S_DATA: begin
          if (idx == 3'd4) begin
`ifdef UART_CMD_CHECKSUM_EN
            state_nxt = S_CHK;
`else
            state_nxt = S_TAIL;
`endif
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        S_CHK: begin
          if (rx_data == chk_xor) state_nxt = S_TAIL;
          else begin
            state_nxt = S_IDLE;
            err       = 1'b1;
          end
        end
`endif
        S_TAIL: begin
          state_nxt = S_IDLE;
          if (rx_data == B_TAIL) commit = 1'b1;
          else                   err    = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Shadow capture of the payload bytes, MSB first.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      idx    <= '0;
    end else if (rx_done) begin
      if (state == S_HDR2) begin
        idx <= '0;
      end else if (state == S_DATA) begin
        shadow[idx] <= rx_data;
        idx         <= idx + 3'd1;
      end
    end
  end

  // Inter-byte timer: idle in IDLE, restarted by every byte and by expiry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                                  tmo_cnt <= '0;
    else if (rx_done || state == S_IDLE || tmo_hit) tmo_cnt <= '0;
    else                                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Committed outputs, status pulses and saturating error count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      time_set  <= TIME_DEFAULT;
      ctrl      <= CTRL_DEFAULT;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      cmd_valid <= commit;
      frame_err <= err;
      if (commit) begin
        time_set <= {shadow[0], shadow[1], shadow[2], shadow[3]};
        ctrl     <= shadow[4];
      end
      if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_rx.sv
// Scoreboard bench for uart_cmd_frame_rx; honours UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_frame_rx;

  localparam int          T      = 40;
  localparam logic [31:0] TS_DEF = 32'd24_999_999;

  typedef logic [7:0] bq_t [$];

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [31:0] time_set;
  logic [7:0]  ctrl;
  logic        cmd_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;

  uart_cmd_frame_rx #(.TIMEOUT_CYC(T)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .time_set(time_set), .ctrl(ctrl), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_err_exp = 0;
  int          n_err_seen = 0;
  logic [39:0] sb [$];
  logic [31:0] cur_ts = TS_DEF;
  logic [7:0]  cur_ctrl = 8'h00;
  logic [7:0]  exp_ecnt = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bq_t mk_frame(input logic [31:0] t, input logic [7:0] c, input logic [7:0] tail);
    bq_t q;
    q.push_back(8'h55); q.push_back(8'hA5);
    q.push_back(t[31:24]); q.push_back(t[23:16]); q.push_back(t[15:8]); q.push_back(t[7:0]);
    q.push_back(c);
`ifdef UART_CMD_CHECKSUM_EN
    q.push_back(t[31:24] ^ t[23:16] ^ t[15:8] ^ t[7:0] ^ c);
`endif
    q.push_back(tail);
    return q;
  endfunction

  // Bytes on successive strobes, 'gap' idle cycles between them; returns at
  // the negedge after the last byte was captured.
  task automatic send_seq(input bq_t q, input int gap);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge sys_clk);
      rx_data = q[i];
      rx_done = 1'b1;
      if (gap > 0 && i < q.size() - 1) begin
        @(negedge sys_clk);
        rx_done = 1'b0;
        repeat (gap - 1) @(negedge sys_clk);
      end
    end
    @(negedge sys_clk);
    rx_done = 1'b0;
  endtask

  task automatic note_err();
    n_err_exp++;
    if (exp_ecnt != 8'hFF) exp_ecnt++;
  endtask

  task automatic run_frame(input string tag, input bq_t q, input int gap, input bit ev, input bit ee,
                           input logic [31:0] ts, input logic [7:0] c);
    if (ev) sb.push_back({ts, c});
    send_seq(q, gap);
    chk({tag, "_cmd_valid"}, cmd_valid, ev);
    chk({tag, "_frame_err"}, frame_err, ee);
    if (ev) begin cur_ts = ts; cur_ctrl = c; end
    if (ee) note_err();
    chk({tag, "_time_set"}, time_set, cur_ts);
    chk({tag, "_ctrl"}, ctrl, cur_ctrl);
    chk({tag, "_err_cnt"}, err_cnt, exp_ecnt);
  endtask

  // Output monitor: every commit must match the oldest expected frame.
  always @(negedge sys_clk) begin
    if (rst_n === 1'b1) begin
      if (frame_err) n_err_seen++;
      if (cmd_valid) begin
        if (sb.size() == 0) chk("sb_unexpected_valid", cmd_valid, 0);
        else begin
          logic [39:0] e;
          e = sb.pop_front();
          chk("sb_time_set", time_set, e[39:8]);
          chk("sb_ctrl", ctrl, e[7:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int  k;
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("rst_time_set", time_set, TS_DEF);
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Basic frame, back-to-back bytes.
    run_frame("f1", mk_frame(32'h017D783F, 8'h0F, 8'hF0), 0, 1, 0, 32'h017D783F, 8'h0F);
    // Resync: extra 0x55 before 0xA5.
    q = mk_frame(32'd16, 8'h01, 8'hF0); q.push_front(8'h55);
    run_frame("resync", q, 1, 1, 0, 32'd16, 8'h01);
    // Noise while idle is ignored.
    q = {}; q.push_back(8'h00); q.push_back(8'hF0); q.push_back(8'hA5);
    run_frame("idle_noise", q, 0, 0, 0, 0, 0);
    // Bad tail.
    run_frame("bad_tail", mk_frame(32'h11223344, 8'h66, 8'hEE), 0, 0, 1, 0, 0);
    // Bad second header byte.
    q = {}; q.push_back(8'h55); q.push_back(8'h12);
    run_frame("bad_hdr2", q, 0, 0, 1, 0, 0);
    // Byte arrives exactly in the expiry cycle: accepted.
    run_frame("gap_edge", mk_frame(32'hDEADBEEF, 8'h5A, 8'hF0), T - 1, 1, 0, 32'hDEADBEEF, 8'h5A);
    // Zero period passes through.
    run_frame("zero_ts", mk_frame(32'h0, 8'hFF, 8'hF0), 0, 1, 0, 32'h0, 8'hFF);

    // Timeout inside a frame.
    q = {}; q.push_back(8'h55); q.push_back(8'hA5); q.push_back(8'h00); q.push_back(8'h00);
    send_seq(q, 0);
    k = 0;
    while (!frame_err && k < T + 10) begin @(negedge sys_clk); k++; end
    chk("tmo_cycles", k, T);
    note_err();
    chk("tmo_err_cnt", err_cnt, exp_ecnt);
    chk("tmo_time_set", time_set, cur_ts);
    run_frame("after_tmo", mk_frame(32'h00000400, 8'h3C, 8'hF0), 0, 1, 0, 32'h00000400, 8'h3C);

`ifdef UART_CMD_CHECKSUM_EN
    q = mk_frame(32'h01020304, 8'h05, 8'hF0);
    q[7] = q[7] ^ 8'h01;
    run_frame("bad_chk", q, 0, 0, 1, 0, 0);
`endif

    // Reset in the middle of a frame.
    q = {}; q.push_back(8'h55); q.push_back(8'hA5);
    q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h56);
    send_seq(q, 0);
    rst_n = 1'b0;
    @(negedge sys_clk);
    chk("mrst_time_set", time_set, TS_DEF);
    chk("mrst_ctrl", ctrl, 8'h00);
    chk("mrst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    cur_ts = TS_DEF; cur_ctrl = 8'h00; exp_ecnt = 8'h00;
    q = {}; q.push_back(8'h78); q.push_back(8'h9A);
`ifdef UART_CMD_CHECKSUM_EN
    q.push_back(8'h00);
`endif
    q.push_back(8'hF0);
    run_frame("mrst_tail", q, 0, 0, 0, 0, 0);

    // Error count saturation.
    q = {}; q.push_back(8'h55); q.push_back(8'h00);
    for (int i = 0; i < 256; i++) run_frame("flood", q, 0, 0, 1, 0, 0);
    chk("sat_err_cnt", err_cnt, 8'hFF);

    repeat (3) @(negedge sys_clk);
    chk("sb_drained", sb.size(), 0);
    chk("err_pulses", n_err_seen, n_err_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
